// File: rtl/demux2_stream_if.sv
// Stream bundle for the 1:2 demultiplexer: one input stream and two buffered output channels.
// The slave modport is the demux's view; the master modport is the producer/consumer side.
interface demux2_stream_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    out0_count;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out1_count;

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_count,
           out1_valid, out1_data, out1_count
  );
endinterface

// File: rtl/demux2_stream.sv
// 1:2 stream demultiplexer: each beat goes to the FIFO picked by in_sel, and each
// output channel drains independently so a stalled consumer only blocks its own channel.
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  demux2_stream_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_out_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_head  [2];
  logic [CW-1:0]    w_count [2];

  // in_ready looks only at registered full flags, never at the consumers' ready.
  assign bus.in_ready = !reset && !w_full[bus.in_sel];
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_out_ready  = {bus.out1_ready, bus.out0_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wr_ptr;
      logic [PW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;

      assign w_full[gi]  = (r_count == CW'(DEPTH));
      assign w_empty[gi] = (r_count == '0);
      assign w_push[gi]  = w_accept && (bus.in_sel == 1'(gi));
      assign w_pop[gi]   = !reset && !w_empty[gi] && w_out_ready[gi];
      assign w_head[gi]  = r_mem[r_rd_ptr];
      assign w_count[gi] = r_count;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
          if (w_pop[gi])  r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= CW'(r_count + 1'b1);
            2'b01:   r_count <= CW'(r_count - 1'b1);
            default: r_count <= r_count;
          endcase
        end
      end

      // Storage carries no reset so it can map onto plain RAM.
      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr_ptr] <= bus.in_data;
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
          assert (r_count <= CW'(DEPTH));
          assert (!(w_push[gi] && w_full[gi]));
        end
      end
    end
  endgenerate

  assign bus.out0_valid = !reset && !w_empty[0];
  assign bus.out0_data  = w_head[0];
  assign bus.out0_count = w_count[0];
  assign bus.out1_valid = !reset && !w_empty[1];
  assign bus.out1_data  = w_head[1];
  assign bus.out1_count = w_count[1];
endmodule

// File: tb/tb_demux2_stream.sv
// Directed and random checks of demux2_stream against a per-channel queue model.
module tb_demux2_stream;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  demux2_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int beats_in = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle starting at a negedge, checks outputs against the model,
  // then applies the handshakes the model says should occur on the rising edge.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy;
    logic psh;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check("in_ready",   32'(bus.in_ready),   32'(exp_rdy));
    check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
    check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
    check("out0_count", 32'(bus.out0_count), 32'(q0.size()));
    check("out1_count", 32'(bus.out1_count), 32'(q1.size()));
    if (q0.size() != 0) check("out0_data", 32'(bus.out0_data), 32'(q0[0]));
    if (q1.size() != 0) check("out1_data", 32'(bus.out1_data), 32'(q1[0]));
    $display("t=%0t in v=%0b s=%0b d=%02h rdy=%0b | o0 v=%0b d=%02h c=%0d | o1 v=%0b d=%02h c=%0d",
             $time, v, s, d, bus.in_ready, bus.out0_valid, bus.out0_data, bus.out0_count,
             bus.out1_valid, bus.out1_data, bus.out1_count);
    psh = v && exp_rdy;
    @(posedge clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (psh) begin
      beats_in++;
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(negedge clk);
  endtask

  // Holds reset with live-looking traffic, which must neither push nor pop.
  task automatic do_reset(input int cycles);
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b0;
    bus.in_data    = 8'hEE;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("rst_out0_count", 32'(bus.out0_count), 32'd0);
    check("rst_out1_count", 32'(bus.out1_count), 32'd0);
    $display("t=%0t reset held %0d cycle(s)", $time, cycles);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    do_reset(2);

    // Reset flush: two beats buffered in ch0 are discarded.
    step(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    check("flush_pre_count", 32'(bus.out0_count), 32'd2);
    do_reset(1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hB1, 1'b0, 1'b1);
    check("flush_head_not_A1", 32'(bus.out0_data != 8'hA1), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Routing and single-cycle latency at full throughput.
    step(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure isolation, then full channel with a simultaneous pop.
    step(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_out0_hold", 32'(bus.out0_data), 32'h01);
    step(1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Random traffic exercising pointer wrap on both channels.
    beats_in = 0;
    cyc = 0;
    while (beats_in < 200 && cyc < 4000) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
           1'($urandom_range(1)), 1'($urandom_range(1)));
      cyc++;
    end
    check("random_beats_done", 32'(beats_in >= 200), 32'd1);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("drained_count0", 32'(bus.out0_count), 32'd0);
    check("drained_count1", 32'(bus.out1_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1:2 stream demultiplexer with per-output buffering; the inverse of the 2:1 data-path mux.
- Routes one valid/ready input stream to output channel 0 or 1 according to a per-beat select.
- Each output channel has an independent FIFO, so a stalled consumer only blocks beats destined for that channel.
- Sits between the pipeline's result/write-back source and two independent consumers, for example the register-file write port and the memory-side store path.

Parameters:
WIDTH  8  bit width of data beats
DEPTH  2  entries per output FIFO; must be a power of two, >= 2

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept beat for channel in_sel
in_data  input  WIDTH  input beat payload
in_sel  input  1  destination channel: 0 -> out0, 1 -> out1; sampled only when in_valid=1
out0_valid  output  1  channel 0 FIFO non-empty
out0_ready  input  1  channel 0 consumer accepts head
out0_data  output  WIDTH  channel 0 FIFO head
out0_count  output  $clog2(DEPTH+1)  channel 0 occupancy
out1_valid  output  1  channel 1 FIFO non-empty
out1_ready  input  1  channel 1 consumer accepts head
out1_data  output  WIDTH  channel 1 FIFO head
out1_count  output  $clog2(DEPTH+1)  channel 1 occupancy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: while reset=1 and in the first cycle after it: in_ready=0 during reset; out0_valid=out1_valid=0; out0_count=out1_count=0; read/write pointers=0.
  - FIFO storage is not reset; outX_data is don't-care while outX_valid=0.
- Reset mid-operation:
  - All buffered beats are discarded. No beat is pushed or popped in a reset cycle, regardless of valid/ready.
  - in_ready=1 from the first cycle after reset deassertion.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. The beat is written into FIFO[in_sel].
  - Output transfer on channel k occurs when outk_valid & outk_ready. The head is popped.
  - Each transfer happens in exactly one cycle.
- in_ready:
  - Combinational, equal to !full[in_sel].
  - Uses registered full flags only. There is no combinational path from out0_ready or out1_ready to in_ready.
- Full channel with simultaneous pop: the push is refused (in_ready=0) even if outk_ready=1 in the same cycle. The pop still occurs, and the push is accepted the next cycle.
- Simultaneous push and pop on a non-full, non-empty channel: both occur and the count is unchanged.
- Empty channel:
  - outk_valid=0. A push in cycle N gives outk_valid=1 with the new data in cycle N+1.
  - There is no same-cycle bypass; latency from acceptance to presentation is exactly 1 cycle.
- Independence: a push to channel 0 and a pop from channel 1 in the same cycle are fully independent.
- Ordering: strict FIFO order within each channel. There is no ordering guarantee between channels.
- Pointers:
  - $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - full/empty are derived from an explicit occupancy counter per channel, range 0..DEPTH.
- outk_count: registered occupancy. It is +1 on push-only, -1 on pop-only, and unchanged on both or neither.
- Stability: while outk_valid=1 and outk_ready=0, outk_data holds stable.
- Input signals when idle: in_sel and in_data are ignored when in_valid=0.
- Simulation assertions:
  - DEPTH is a power of two and >= 2.
  - outk_count never exceeds DEPTH.
  - No push occurs while full.

Test Plan:
- Reset flush (WIDTH=8, DEPTH=2): push 0xA1 and 0xA2 to ch0, then assert reset 1 cycle without popping. Required: out0_valid=0, out0_count=0, in_ready=0 during reset and 1 after. A later pop never yields 0xA1.
- Routing and latency: with out0_ready=out1_ready=1, drive the beats 0x11/sel0, 0x22/sel1, 0x33/sel0 back-to-back. Required:
  - out0 shows 0x11 one cycle after acceptance, then 0x33.
  - out1 shows 0x22.
  - in_ready stays 1 throughout, sustaining 1 beat/cycle.
- Backpressure isolation: out0_ready=0; push 0x01 and 0x02 to ch0. Required:
  - out0_count=2 and in_ready=0 when in_sel=0.
  - Switching to in_sel=1 accepts 0x55 immediately (in_ready=1), and out1 delivers 0x55.
  - out0_data holds 0x01 throughout.
- Full with simultaneous pop: ch0 full (0x01, 0x02), out0_ready=1, in_valid=1, in_sel=0, in_data=0x03. Required:
  - Cycle N: in_ready=0 and 0x01 popped.
  - Cycle N+1: in_ready=1, 0x03 accepted.
  - Final order out of ch0 is 0x01, 0x02, 0x03.
- Wrap-around: random valid/ready at 50%, 200 beats with random sel. Required: each channel's output sequence equals the scoreboard order, counts never exceed 2, and no assertion fires.
